botoes_debounce: RTL and testbench

- Input conditioning stage directly upstream of the zoom/scale selector.
- Synchronises the two raw push-buttons and the 3-bit algorithm switch word into the clk domain and debounces them.
- Delivers glitch-free levels on which the selector's edge/change detection can act safely.
- Button polarity is preserved: active-low, released = 1. The switch word changes atomically, never through intermediate codes.

---
 rtl/botoes_debounce_pkg.sv | 13 +
 rtl/botoes_debounce_canal.sv | 70 +++++++
 rtl/botoes_debounce.sv | 39 +++
 tb/tb_botoes_debounce.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/botoes_debounce_pkg.sv
// Shared constants for the button/switch conditioning stage ahead of the zoom selector.
package botoes_debounce_pkg;

    localparam logic BUT_IDLE             = 1'b1;
    localparam int   ALG_RESET            = 0;
    localparam int   DB_CYCLES_50MHZ_20MS = 1_000_000;
    localparam int   SYNC_STAGES_DEF      = 2;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/botoes_debounce_canal.sv
// One debounce channel: synchroniser chain, candidate register, stability counter and
// registered output. A WIDTH-bit word commits atomically once it has held steady.
module debounce_canal
    import botoes_debounce_pkg::*;
#(
    parameter int               WIDTH       = 1,
    parameter logic [WIDTH-1:0] RST_VAL     = '0,
    parameter int               DB_CYCLES   = DB_CYCLES_50MHZ_20MS,
    parameter int               SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din_raw,
    output logic [WIDTH-1:0] dout
);

    localparam int             CW      = cnt_width(DB_CYCLES);
    localparam logic [CW-1:0]  CNT_MAX = CW'(DB_CYCLES - 1);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
    logic [WIDTH-1:0]                  cand_q, cand_d;
    logic [WIDTH-1:0]                  stable_q, stable_d;
    logic [CW-1:0]                     cnt_q, cnt_d;
    logic [WIDTH-1:0]                  sync_last;

    assign sync_last = sync_q[SYNC_STAGES-1];
    assign dout      = stable_q;

    always_comb begin
        sync_d[0] = din_raw;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    // Any disagreement between the synchronised value and the candidate restarts the
    // count, so a skewed switch word only commits once every bit has settled.
    always_comb begin
        cand_d   = cand_q;
        cnt_d    = cnt_q;
        stable_d = stable_q;
        if (sync_last == stable_q) begin
            cand_d = sync_last;
            cnt_d  = '0;
        end else if (sync_last != cand_q) begin
            cand_d = sync_last;
            cnt_d  = '0;
        end else if (cnt_q == CNT_MAX) begin
            stable_d = cand_q;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q   <= {SYNC_STAGES{RST_VAL}};
            cand_q   <= RST_VAL;
            stable_q <= RST_VAL;
            cnt_q    <= '0;
        end else begin
            sync_q   <= sync_d;
            cand_q   <= cand_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/botoes_debounce.sv
// Conditions the two active-low zoom buttons and the algorithm switch word into clean,
// clk-domain levels for the zoom/scale selector. Channels are fully independent.
module botoes_debounce
    import botoes_debounce_pkg::*;
#(
    parameter int DB_CYCLES   = DB_CYCLES_50MHZ_20MS,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int SW_W        = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            but_zoom_in_raw,
    input  logic            but_zoom_out_raw,
    input  logic [SW_W-1:0] escolha_alg_raw,
    output logic            but_zoom_in,
    output logic            but_zoom_out,
    output logic [SW_W-1:0] escolha_alg
);

    debounce_canal #(
        .WIDTH(1), .RST_VAL(BUT_IDLE), .DB_CYCLES(DB_CYCLES), .SYNC_STAGES(SYNC_STAGES)
    ) u_zoom_in (
        .clk(clk), .rst(rst), .din_raw(but_zoom_in_raw), .dout(but_zoom_in)
    );

    debounce_canal #(
        .WIDTH(1), .RST_VAL(BUT_IDLE), .DB_CYCLES(DB_CYCLES), .SYNC_STAGES(SYNC_STAGES)
    ) u_zoom_out (
        .clk(clk), .rst(rst), .din_raw(but_zoom_out_raw), .dout(but_zoom_out)
    );

    debounce_canal #(
        .WIDTH(SW_W), .RST_VAL(SW_W'(ALG_RESET)), .DB_CYCLES(DB_CYCLES),
        .SYNC_STAGES(SYNC_STAGES)
    ) u_alg (
        .clk(clk), .rst(rst), .din_raw(escolha_alg_raw), .dout(escolha_alg)
    );

endmodule

// File: tb/tb_botoes_debounce.sv
// Directed bench for botoes_debounce with DB_CYCLES=8, SYNC_STAGES=2.
// Edge k=1 is the first posedge that samples a new raw value; a held step commits on k=11.
module tb_botoes_debounce;

    logic       clk = 1'b0;
    logic       rst;
    logic       zi_raw, zo_raw;
    logic [2:0] alg_raw;
    logic       zi, zo;
    logic [2:0] alg;

    int checks = 0;
    int errors = 0;

    botoes_debounce #(.DB_CYCLES(8), .SYNC_STAGES(2), .SW_W(3)) dut (
        .clk(clk), .rst(rst),
        .but_zoom_in_raw(zi_raw), .but_zoom_out_raw(zo_raw), .escolha_alg_raw(alg_raw),
        .but_zoom_in(zi), .but_zoom_out(zo), .escolha_alg(alg)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        logic [4:0] exp;
        rst = 1'b0; zi_raw = 1'b0; zo_raw = 1'b0; alg_raw = 3'b101;
        repeat (4) @(negedge clk);
        checks++;
        if ({zi, zo, alg} !== 5'b11000) begin
            errors++;
            $display("FAIL reset_hold got %b exp %b", {zi, zo, alg}, 5'b11000);
        end
        rst = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            exp = (k >= 11) ? 5'b00101 : 5'b11000;
            checks++;
            if ({zi, zo, alg} !== exp) begin
                errors++;
                $display("FAIL reset_release edge %0d got %b exp %b", k, {zi, zo, alg}, exp);
            end
        end
    endtask

    task automatic test_clean_press();
        logic [1:0] exp;
        zi_raw = 1'b1; zo_raw = 1'b1;
        repeat (15) @(negedge clk);
        checks++;
        if ({zi, zo} !== 2'b11) begin
            errors++;
            $display("FAIL press_idle got %b exp %b", {zi, zo}, 2'b11);
        end
        zi_raw = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            exp = (k >= 11) ? 2'b01 : 2'b11;
            checks++;
            if ({zi, zo} !== exp) begin
                errors++;
                $display("FAIL press_fall edge %0d got %b exp %b", k, {zi, zo}, exp);
            end
        end
        zi_raw = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            exp = (k >= 11) ? 2'b11 : 2'b01;
            checks++;
            if ({zi, zo} !== exp) begin
                errors++;
                $display("FAIL press_rise edge %0d got %b exp %b", k, {zi, zo}, exp);
            end
        end
    endtask

    task automatic test_bounce();
        logic exp;
        for (int k = 0; k < 30; k++) begin
            zo_raw = ((k / 3) % 2 == 0) ? 1'b0 : 1'b1;
            @(negedge clk);
            checks++;
            if (zo !== 1'b1) begin
                errors++;
                $display("FAIL bounce_toggle cycle %0d got %b exp 1", k, zo);
            end
        end
        zo_raw = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            exp = (k >= 11) ? 1'b0 : 1'b1;
            checks++;
            if (zo !== exp) begin
                errors++;
                $display("FAIL bounce_settle edge %0d got %b exp %b", k, zo, exp);
            end
        end
        zo_raw = 1'b1;
        repeat (12) @(negedge clk);
        checks++;
        if (zo !== 1'b1) begin
            errors++;
            $display("FAIL bounce_restore got %b exp 1", zo);
        end
    endtask

    task automatic test_glitch();
        logic exp;
        zi_raw = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 7) zi_raw = 1'b1;
            checks++;
            if (zi !== 1'b1) begin
                errors++;
                $display("FAIL glitch_short edge %0d got %b exp 1", k, zi);
            end
        end
        // Nine raw cycles gives DB_CYCLES+1 decision edges on the synchronised value,
        // the minimum for a restart plus a full count to commit.
        zi_raw = 1'b0;
        for (int k = 1; k <= 22; k++) begin
            @(negedge clk);
            if (k == 9) zi_raw = 1'b1;
            exp = (k >= 11 && k < 20) ? 1'b0 : 1'b1;
            checks++;
            if (zi !== exp) begin
                errors++;
                $display("FAIL glitch_long edge %0d got %b exp %b", k, zi, exp);
            end
        end
    endtask

    task automatic test_skewed_switch();
        logic [2:0] exp;
        alg_raw = 3'b000;
        repeat (14) @(negedge clk);
        checks++;
        if (alg !== 3'b000) begin
            errors++;
            $display("FAIL skew_base got %b exp %b", alg, 3'b000);
        end
        alg_raw = 3'b001;
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (alg !== 3'b000) begin
                errors++;
                $display("FAIL skew_partial got %b exp %b", alg, 3'b000);
            end
        end
        alg_raw = 3'b011;
        for (int k = 1; k <= 13; k++) begin
            @(negedge clk);
            exp = (k >= 11) ? 3'b011 : 3'b000;
            checks++;
            if (alg !== exp) begin
                errors++;
                $display("FAIL skew_commit edge %0d got %b exp %b", k, alg, exp);
            end
        end
    endtask

    task automatic test_mid_reset();
        logic [4:0] exp;
        zi_raw = 1'b0;
        repeat (8) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({zi, zo, alg} !== 5'b11000) begin
            errors++;
            $display("FAIL midrst_async got %b exp %b", {zi, zo, alg}, 5'b11000);
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            exp = (k >= 11) ? 5'b01011 : 5'b11000;
            checks++;
            if ({zi, zo, alg} !== exp) begin
                errors++;
                $display("FAIL midrst_release edge %0d got %b exp %b", k, {zi, zo, alg}, exp);
            end
        end
        // Reset while an output is already committed low must force it back at once.
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({zi, zo, alg} !== 5'b11000) begin
            errors++;
            $display("FAIL midrst_committed got %b exp %b", {zi, zo, alg}, 5'b11000);
        end
        rst = 1'b1;
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_glitch();
        test_skewed_switch();
        test_mid_reset();
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
